// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a
// load/store requester. A three-state FSM (IDLE/FETCH/DATA) grants one
// access at a time, waits for mem_ready and abandons the access with
// mem_error after TIMEOUT_CYCLES cycles without mem_ready.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to make simultaneous
// requests alternate. Without it, data always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_grant,
  output logic                  fetch_done,
  output logic [31:0]           fetch_data,
  input  logic                  data_req,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_grant,
  output logic                  data_done,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  mem_error,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  // The timeout fires from the last waiting cycle so that done lands
  // exactly TIMEOUT_CYCLES cycles after the grant.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_next;
  logic       write_q;
  logic [7:0] wait_cnt;
  logic       pick_fetch, pick_data;
  logic       timeout_hit, access_end;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 when the most recent grant went to the data requester.
  logic last_data;

  // Round-robin pointer, follows every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_data <= 1'b1;
    else if (pick_fetch) last_data <= 1'b0;
    else if (pick_data)  last_data <= 1'b1;
  end
`endif

  // Arbitration: requests are only considered while idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    pick_fetch = 1'b0;
    pick_data  = 1'b0;
    if (state == IDLE) begin
      if (fetch_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (last_data) pick_fetch = 1'b1;
        else           pick_data  = 1'b1;
`else
        pick_data = 1'b1;
`endif
      end else if (fetch_req) begin
        pick_fetch = 1'b1;
      end else if (data_req) begin
        pick_data = 1'b1;
      end
    end
  end

  // A ready in the timeout cycle wins over the timeout.
  assign timeout_hit = (state != IDLE) && !mem_ready && (wait_cnt == LAST_WAIT);
  assign access_end  = (state != IDLE) && (mem_ready || timeout_hit);

  // State register; reset asynchronously returns to IDLE mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_fetch)     state_next = FETCH;
        else if (pick_data) state_next = DATA;
      end
      FETCH, DATA: begin
        if (access_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes and busy decode straight from state, so they drop the
  // moment reset forces IDLE.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        busy     = 1'b1;
      end
      DATA: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered pulses, operand capture, wait counter and read results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_grant <= 1'b0;
      data_grant  <= 1'b0;
      fetch_done  <= 1'b0;
      data_done   <= 1'b0;
      mem_error   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      write_q     <= 1'b0;
      wait_cnt    <= '0;
      fetch_data  <= '0;
      data_rdata  <= '0;
    end else begin
      fetch_grant <= pick_fetch;
      data_grant  <= pick_data;
      fetch_done  <= access_end && (state == FETCH);
      data_done   <= access_end && (state == DATA);
      mem_error   <= timeout_hit;

      if (pick_fetch) begin
        mem_address <= fetch_address;
        write_q     <= 1'b0;
        wait_cnt    <= '0;
      end else if (pick_data) begin
        mem_address <= data_address;
        mem_wdata   <= data_wdata;
        write_q     <= data_write;
        wait_cnt    <= '0;
      end else if ((state != IDLE) && !access_end) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // A timed-out read returns zero; a store never touches data_rdata.
      if ((state == FETCH) && access_end)
        fetch_data <= mem_ready ? mem_rdata[31:0] : '0;
      if ((state == DATA) && access_end && !write_q)
        data_rdata <= mem_ready ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a vector table of single
// accesses driven back to back, then reset-mid-access, tie arbitration
// and idle mem_ready sequences. Completions are checked by a monitor
// against a scoreboard queue filled as each request is driven.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req, data_req, data_write;
  logic [AW-1:0] fetch_address, data_address;
  logic [DW-1:0] data_wdata, mem_rdata;
  logic          mem_ready;
  logic          fetch_grant, fetch_done, data_grant, data_done;
  logic [31:0]   fetch_data;
  logic [DW-1:0] data_rdata, mem_wdata;
  logic [AW-1:0] mem_address;
  logic          mem_read, mem_write, mem_error, busy;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_address(fetch_address),
    .fetch_grant(fetch_grant), .fetch_done(fetch_done), .fetch_data(fetch_data),
    .data_req(data_req), .data_write(data_write),
    .data_address(data_address), .data_wdata(data_wdata),
    .data_grant(data_grant), .data_done(data_done), .data_rdata(data_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_error(mem_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_data;
    logic          wr;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    int            wait_cycles;
    logic          exp_err;
    logic [63:0]   exp_rd;
  } vec_t;

  typedef struct {
    logic        is_data;
    logic        err;
    logic [63:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] model_fd = '0;
  logic [63:0] model_dr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (fetch_done || data_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {62'b0, fetch_done, data_done}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        check("done_kind", {62'b0, fetch_done, data_done}, {62'b0, ~mon_e.is_data, mon_e.is_data});
        check("done_error", {63'b0, mem_error}, {63'b0, mon_e.err});
        if (mon_e.is_data) check("data_rdata", data_rdata, mon_e.rd);
        else               check("fetch_data", {32'b0, fetch_data}, mon_e.rd);
      end
    end
  end

  // Drives one access from an idle negedge and follows it to completion,
  // returning at the negedge of the done cycle.
  task automatic run_txn(input vec_t v, input logic tie);
    int   gw;
    int   k;
    int   lat;
    int   good;
    int   exp_lat;
    logic exp_rd_s, exp_wr_s;
    sb.push_back('{v.is_data, v.exp_err, v.exp_rd});
    if (v.is_data) model_dr = v.exp_rd;
    else           model_fd = v.exp_rd;
    fetch_address = v.addr;
    data_address  = v.addr;
    data_write    = v.wr;
    data_wdata    = v.wdata;
    mem_rdata     = v.rdata;
    mem_ready     = 1'b0;
    fetch_req     = tie | ~v.is_data;
    data_req      = tie | v.is_data;
    gw = 0;
    do begin
      @(negedge clk);
      gw++;
    end while (!(fetch_grant || data_grant) && gw < 8);
    check("grant_latency", 64'(gw), 64'd1);
    check("grant_kind", {62'b0, fetch_grant, data_grant}, {62'b0, ~v.is_data, v.is_data});
    fetch_req = 1'b0;
    data_req  = 1'b0;

    exp_rd_s = ~v.is_data | ~v.wr;
    exp_wr_s = v.is_data & v.wr;
    exp_lat  = (v.wait_cycles <= TO - 1) ? v.wait_cycles + 1 : TO;
    k = 0; lat = -1; good = 0;
    while (k < 40) begin
      if (fetch_done || data_done) begin
        lat = k;
        break;
      end
      if (busy && mem_read == exp_rd_s && mem_write == exp_wr_s && mem_address == v.addr &&
          (!exp_wr_s || mem_wdata == v.wdata))
        good++;
      mem_ready = (k == v.wait_cycles);
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    check("done_latency", 64'(lat), 64'(exp_lat));
    check("strobe_cycles", 64'(good), 64'(exp_lat));
    check("idle_after_done", {61'b0, busy, mem_read, mem_write}, 64'h0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv;
    logic win_data;
    int   gw;

    vecs[0] = '{1'b0, 1'b0, 64'h40,  64'h0,    64'h8B020020,            0,   1'b0, 64'h8B020020};
    vecs[1] = '{1'b1, 1'b0, 64'h100, 64'h0,    64'hDEADBEEF_CAFEF00D,   2,   1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 64'h80,  64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 3,   1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 64'h44,  64'h0,    64'h11112222_33334444,   5,   1'b0, 64'h33334444};
    vecs[4] = '{1'b1, 1'b0, 64'h200, 64'h0,    64'h55,                  15,  1'b0, 64'h55};
    vecs[5] = '{1'b1, 1'b0, 64'h208, 64'h0,    64'h77,                  16,  1'b1, 64'h0};
    vecs[6] = '{1'b0, 1'b0, 64'h48,  64'h0,    64'h99,                  200, 1'b1, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 64'h300, 64'h0,    64'hABCD,                1,   1'b0, 64'hABCD};
    vecs[8] = '{1'b1, 1'b1, 64'h88,  64'h5678, 64'h1,                   16,  1'b1, 64'hABCD};

    rst_n = 1'b0;
    fetch_req = 1'b0; data_req = 1'b0; data_write = 1'b0;
    fetch_address = '0; data_address = '0; data_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #1;
    check("reset_ctrl", {56'b0, fetch_grant, fetch_done, data_grant, data_done,
                         mem_read, mem_write, mem_error, busy}, 64'h0);
    check("reset_fetch_data", {32'b0, fetch_data}, 64'h0);
    check("reset_data_rdata", data_rdata, 64'h0);
    check("reset_mem_address", mem_address, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single accesses, back to back.
    for (int i = 0; i < 9; i++) run_txn(vecs[i], 1'b0);

    // Reset asserted between edges in the middle of a load.
    data_address = 64'h500; data_write = 1'b0; data_req = 1'b1; mem_ready = 1'b0;
    gw = 0;
    do begin
      @(negedge clk);
      gw++;
    end while (!data_grant && gw < 8);
    data_req = 1'b0;
    check("rst_mid_grant", {63'b0, data_grant}, 64'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    check("rst_mid_read_before", {62'b0, mem_read, busy}, 64'h3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {61'b0, mem_read, mem_write, busy}, 64'h0);
    check("rst_mid_data_rdata", data_rdata, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_fd = '0;
    model_dr = '0;
    @(negedge clk);

    // Simultaneous requests, four rounds, each re-raised in the done cycle.
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_data = (i % 2 == 1);
`else
      win_data = 1'b1;
`endif
      tv.is_data     = win_data;
      tv.wr          = 1'b0;
      tv.addr        = 64'h600 + 64'(i * 8);
      tv.wdata       = '0;
      tv.rdata       = {32'hA5A50000 + 32'(i), 32'h10000000 + 32'(i)};
      tv.wait_cycles = 0;
      tv.exp_err     = 1'b0;
      tv.exp_rd      = win_data ? tv.rdata : {32'b0, tv.rdata[31:0]};
      run_txn(tv, 1'b1);
    end

    // mem_ready in IDLE with no request must be ignored.
    mem_ready = 1'b1;
    mem_rdata = 64'hFEED_FACE_0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_ctrl", {58'b0, fetch_grant, data_grant, fetch_done, data_done,
                                busy, mem_error}, 64'h0);
      check("idle_ready_fetch_data", {32'b0, fetch_data}, model_fd);
      check("idle_ready_data_rdata", data_rdata, model_dr);
    end
    mem_ready = 1'b0;
    @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 64: width of data write/read and memory data ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of cycles the block waits for mem_ready, range 1..255.
REQ-004 clock  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 fetch_req  in  1  instruction-fetch request, level.
REQ-007 fetch_address  in  ADDR_WIDTH  fetch address (the PC).
REQ-008 fetch_grant / fetch_done  out  1 each  grant pulse / completion pulse for fetch.
REQ-009 fetch_data  out  32  instruction word, low 32 bits of mem_rdata.
REQ-010 data_req, data_write  in  1 each  load/store request; data_write 1 means store.
REQ-011 data_address, data_wdata  in  ADDR_WIDTH, DATA_WIDTH  load/store address and store data.
REQ-012 data_grant / data_done  out  1 each  grant pulse / completion pulse for data.
REQ-013 data_rdata  out  DATA_WIDTH  load result.
REQ-014 mem_read, mem_write  out  1 each  memory command strobes, mutually exclusive.
REQ-015 mem_address, mem_wdata  out  ADDR_WIDTH, DATA_WIDTH  memory address and write data.
REQ-016 mem_rdata, mem_ready  in  DATA_WIDTH, 1  memory read data and access-complete.
REQ-017 mem_error  out  1  timeout flag, valid with the done pulse.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, FETCH and DATA.
REQ-020 Requests SHALL be sampled only in IDLE; a request arriving in another state waits.
REQ-021 IDLE with a request SHALL, on the next edge, move to FETCH or DATA, pulse the matching grant for exactly one cycle, and register the address, data_write and wdata.
REQ-022 In FETCH, mem_read SHALL be 1; in DATA, mem_read = ~data_write and mem_write = data_write. Address and wdata SHALL stay stable until exit.
REQ-023 Requester SHALL hold req and its operands until grant, and deassert req no later than the cycle after grant.
REQ-024 mem_ready=1 in FETCH/DATA SHALL cause, on the next edge: state to IDLE, mem strobes to 0, one-cycle done pulse, and mem_rdata captured into fetch_data (low 32 bits) or data_rdata; mem_error 0.
REQ-025 A store SHALL leave data_rdata unchanged. Read outputs SHALL hold until the next completion of the same requester.
REQ-026 Minimum latency: req at cycle N, grant at N+1, done at N+2 when mem_ready=1 at N+1.
REQ-027 An 8-bit wait counter SHALL clear at grant and increment each cycle without mem_ready.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the transaction SHALL be abandoned: done pulse with mem_error=1, read output written 0, state to IDLE.
REQ-029 mem_ready=1 in the same cycle as timeout SHALL count as success.
REQ-030 mem_ready SHALL be ignored in IDLE.
REQ-031 A new grant SHALL be possible in the cycle after done, which gives back-to-back throughput of one access per 2 cycles plus the wait cycles.

Reset
REQ-032 When reset=0, state SHALL be IDLE. All outputs SHALL be 0, including fetch_data and data_rdata. The counter and the round-robin pointer SHALL be cleared.
REQ-033 Reset during FETCH/DATA SHALL drop mem strobes asynchronously and abandon the transaction with no done pulse.
REQ-034 After reset release, the first sampling edge SHALL treat requests as new.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL alternate. The pointer resets to "data last", so the first tie goes to fetch. The pointer updates on each grant.
REQ-036 Macro undefined: simultaneous requests SHALL always grant data (fixed priority). There SHALL be no pointer register.

Verification
REQ-037 fetch_req with address 0x40, mem_ready tied 1, mem_rdata=0x8B020020 -> fetch_grant at N+1, fetch_done at N+2, fetch_data=0x8B020020, mem_error=0.
REQ-038 Store to 0x80 with data 0x1234, mem_ready after 3 wait cycles -> mem_write high 4 cycles, address 0x80, data_done 1 cycle later, data_rdata unchanged.
REQ-039 fetch_req and data_req in the same cycle, repeated 4 times -> without the macro: data, data, data, data; with the macro: fetch, data, fetch, data.
REQ-040 Load, mem_ready never asserted, TIMEOUT_CYCLES=16 -> data_done with mem_error=1 16 cycles after grant, data_rdata=0, state IDLE.
REQ-041 reset=0 asynchronously mid-DATA (between edges) -> mem_read/mem_write 0 before the next edge, no data_done, busy 0.
REQ-042 mem_ready=1 during IDLE with no request -> no grant, no done, outputs unchanged.
